maze_grid_store: RTL and testbench
==================================

Name: maze_grid_store

Overview:
- Cell memory directly downstream of the GPIO data-input stage.
- Consumes the one-cycle write pulse plus the X/Y/VALUE fields that stage produces, and stores a 2-bit value per grid cell.
- Serves a registered read port to the VGA/renderer side.
- Self-clears the whole grid after reset, and reports write activity and dropped writes.

Parameters:
- X_BITS, 4, width of the X coordinate (grid width = 2^X_BITS)
- Y_BITS, 4, width of the Y coordinate (grid height = 2^Y_BITS)
- VAL_BITS, 2, bits stored per cell
- CLEAR_VALUE, 0, value written to every cell by the post-reset clear

Ports:
- CLOCK_50  input  1  system clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- WR_EN  input  1  write strobe from the data-input stage (one cycle per transfer)
- WR_X  input  X_BITS  write column
- WR_Y  input  Y_BITS  write row
- WR_VALUE  input  VAL_BITS  value to store
- RD_X  input  X_BITS  read column
- RD_Y  input  Y_BITS  read row
- RD_VALUE  output  VAL_BITS  registered cell value for the address presented on the previous cycle
- BUSY  output  1  high while the clear sequencer runs
- CELL_CHANGED  output  1  one-cycle pulse: the last accepted write altered the stored value
- WR_COUNT  output  8  count of accepted writes, wraps 255->0
- WR_DROPPED  output  1  sticky flag: a write arrived while BUSY

Behaviour:
- Storage: 2^(X_BITS+Y_BITS) cells of VAL_BITS. Cell index = {Y, X}.
- FSM states:
  - CLEAR: entered on any cycle with RESET high. Each non-reset cycle writes CLEAR_VALUE to cell clr_addr, then increments clr_addr. After the cycle that writes the last index (255 with defaults), the next state is RUN.
  - RUN: normal operation. Stays in RUN until RESET.
- Reset values (state after a rising edge with RESET high): state=CLEAR, clr_addr=0, BUSY=1, RD_VALUE=0, CELL_CHANGED=0, WR_COUNT=0, WR_DROPPED=0. Cell contents are not reset directly; the clear sequencer handles them.
- Clear timing: with defaults, BUSY stays high for exactly 256 cycles after RESET deasserts, and is low on the 257th.
- RESET asserted mid-clear restarts the clear from index 0.
- RESET asserted in RUN re-enters CLEAR; all cells are cleared again.
- Writes in RUN:
  - WR_EN=1 → cell[{WR_Y,WR_X}] <= WR_VALUE at that edge.
  - WR_COUNT increments at the same edge.
  - CELL_CHANGED=1 on the next cycle iff WR_VALUE != old cell value; otherwise 0.
  - CELL_CHANGED is 0 on any cycle not following an accepted write.
- Writes in CLEAR (BUSY=1) with WR_EN=1:
  - Write ignored; memory and WR_COUNT unchanged.
  - WR_DROPPED <= 1 and holds until RESET.
- Back-to-back writes (WR_EN high on consecutive cycles) are each accepted independently; no gap cycle is required.
- Read path:
  - RD_VALUE at edge n+1 = contents of {RD_Y,RD_X} sampled at edge n. Latency 1 cycle.
  - Write-first: if in RUN a write and read target the same cell on the same edge, RD_VALUE returns the new WR_VALUE.
  - During CLEAR, RD_VALUE returns CLEAR_VALUE regardless of address.
- Out-of-range addresses are impossible; coordinate widths exactly cover the grid.
- No combinational path from any input to any output.

Test Plan:
- Reset clear: pulse RESET for 1 cycle, then preload-free → BUSY high exactly 256 cycles. Then read all 256 addresses → each RD_VALUE=0 one cycle after its address; WR_COUNT=0; WR_DROPPED=0.
- Basic write/read: after clear, WR_EN pulse with X=3, Y=5, VALUE=2 → next cycle CELL_CHANGED=1, WR_COUNT=1. Read X=3, Y=5 → RD_VALUE=2 after one cycle; X=5, Y=3 reads 0.
- No-change write: write X=3, Y=5, VALUE=2 again → CELL_CHANGED=0, WR_COUNT=2. Write VALUE=1 to the same cell → CELL_CHANGED=1, RD_VALUE=1.
- Write-first collision: same edge WR X=15, Y=15, VALUE=3 and RD X=15, Y=15 → RD_VALUE=3 on the next cycle.
- Dropped write: WR_EN with X=1, Y=1, VALUE=3 at cycle 10 of the clear → WR_DROPPED=1 persists. After BUSY falls, cell (1,1) reads 0 and WR_COUNT=0.
- Reset mid-clear and count wrap:
  - Assert RESET at clear cycle 100 → BUSY stays high 256 further cycles.
  - Then issue 257 writes → WR_COUNT=1.

Source files
------------

// File: rtl/maze_grid_store.sv
// maze_grid_store: 2^(X+Y)-cell grid memory; write pulse in (WR_*), registered write-first read (RD_X/RD_Y -> RD_VALUE), post-reset clear (BUSY), CELL_CHANGED pulse, WR_COUNT, sticky WR_DROPPED
module maze_grid_store #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4,
  parameter int VAL_BITS = 2,
  parameter logic [VAL_BITS-1:0] CLEAR_VALUE = '0
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                WR_EN,
  input  logic [X_BITS-1:0]   WR_X,
  input  logic [Y_BITS-1:0]   WR_Y,
  input  logic [VAL_BITS-1:0] WR_VALUE,
  input  logic [X_BITS-1:0]   RD_X,
  input  logic [Y_BITS-1:0]   RD_Y,
  output logic [VAL_BITS-1:0] RD_VALUE,
  output logic                BUSY,
  output logic                CELL_CHANGED,
  output logic [7:0]          WR_COUNT,
  output logic                WR_DROPPED
);
  localparam int A_BITS = X_BITS + Y_BITS;
  localparam int CELLS = 1 << A_BITS;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [A_BITS-1:0] clr_addr, wa, ra, ma;
  logic [VAL_BITS-1:0] mem [CELLS];
  logic [VAL_BITS-1:0] md;
  logic run, acc, mwe;
  always_comb begin
    wa = {WR_Y, WR_X};
    ra = {RD_Y, RD_X};
    run = state == RUN;
    acc = run && WR_EN && !RESET;
    mwe = !RESET && (!run || WR_EN);
    ma = run ? wa : clr_addr;
    md = run ? WR_VALUE : CLEAR_VALUE;
    BUSY = !run;
  end
  always_ff @(posedge CLOCK_50)
    if (mwe) mem[ma] <= md;
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= CLEAR;
      clr_addr <= '0;
      RD_VALUE <= '0;
      CELL_CHANGED <= 1'b0;
      WR_COUNT <= '0;
      WR_DROPPED <= 1'b0;
    end else begin
      if (!run) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == '1) state <= RUN;
        if (WR_EN) WR_DROPPED <= 1'b1;
      end
      RD_VALUE <= !run ? CLEAR_VALUE : (WR_EN && ra == wa) ? WR_VALUE : mem[ra];
      CELL_CHANGED <= acc && mem[wa] != WR_VALUE;
      if (acc) WR_COUNT <= WR_COUNT + 1'b1;
    end
  end
endmodule

// File: tb/tb_maze_grid_store.sv
// tb_maze_grid_store: directed self-checking bench for maze_grid_store
module tb_maze_grid_store;
  logic CLOCK_50 = 0, RESET = 0, WR_EN = 0;
  logic [3:0] WR_X = 0, WR_Y = 0, RD_X = 0, RD_Y = 0;
  logic [1:0] WR_VALUE = 0, RD_VALUE;
  logic BUSY, CELL_CHANGED, WR_DROPPED;
  logic [7:0] WR_COUNT;
  int checks = 0, failures = 0, n;
  maze_grid_store dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .WR_EN(WR_EN), .WR_X(WR_X), .WR_Y(WR_Y),
    .WR_VALUE(WR_VALUE), .RD_X(RD_X), .RD_Y(RD_Y), .RD_VALUE(RD_VALUE), .BUSY(BUSY),
    .CELL_CHANGED(CELL_CHANGED), .WR_COUNT(WR_COUNT), .WR_DROPPED(WR_DROPPED)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic do_reset();
    RESET = 1;
    tick();
    RESET = 0;
  endtask
  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (BUSY && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask
  task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic [1:0] v);
    WR_X = x; WR_Y = y; WR_VALUE = v; WR_EN = 1;
    tick();
    WR_EN = 0;
  endtask
  task automatic rd(input string tag, input logic [3:0] x, input logic [3:0] y, input logic [1:0] exp);
    RD_X = x; RD_Y = y;
    tick();
    check(tag, RD_VALUE, exp);
  endtask
  initial begin
    do_reset();
    check("rst_busy", BUSY, 1);
    check("rst_rd", RD_VALUE, 0);
    check("rst_cc", CELL_CHANGED, 0);
    check("rst_cnt", WR_COUNT, 0);
    check("rst_drop", WR_DROPPED, 0);
    wait_clear(n);
    check("clear_len", n, 256);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      rd("clear_cell", a[3:0], a[7:4], 0);
    end
    check("clear_cnt", WR_COUNT, 0);
    check("clear_drop", WR_DROPPED, 0);
    wr(3, 5, 2);
    check("w1_cc", CELL_CHANGED, 1);
    check("w1_cnt", WR_COUNT, 1);
    tick();
    check("idle_cc", CELL_CHANGED, 0);
    rd("rd_35", 3, 5, 2);
    rd("rd_53", 5, 3, 0);
    wr(3, 5, 2);
    check("same_cc", CELL_CHANGED, 0);
    check("same_cnt", WR_COUNT, 2);
    wr(3, 5, 1);
    check("chg_cc", CELL_CHANGED, 1);
    check("chg_cnt", WR_COUNT, 3);
    rd("rd_35b", 3, 5, 1);
    RD_X = 15; RD_Y = 15;
    wr(15, 15, 3);
    check("wf_rd", RD_VALUE, 3);
    check("wf_cc", CELL_CHANGED, 1);
    check("wf_cnt", WR_COUNT, 4);
    WR_X = 0; WR_Y = 0; WR_VALUE = 1; WR_EN = 1;
    tick();
    check("b2b_cc0", CELL_CHANGED, 1);
    WR_X = 1; WR_VALUE = 2;
    tick();
    WR_EN = 0;
    check("b2b_cc1", CELL_CHANGED, 1);
    check("b2b_cnt", WR_COUNT, 6);
    rd("b2b_rd0", 0, 0, 1);
    rd("b2b_rd1", 1, 0, 2);
    rd("rd_ff", 15, 15, 3);
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    RD_X = 3; RD_Y = 5;
    wr(1, 1, 3);
    check("drop_flag", WR_DROPPED, 1);
    check("drop_cnt", WR_COUNT, 0);
    check("busy_rd", RD_VALUE, 0);
    wait_clear(n);
    check("drop_len", n, 245);
    check("drop_hold", WR_DROPPED, 1);
    check("drop_cnt2", WR_COUNT, 0);
    rd("drop_cell", 1, 1, 0);
    rd("reclr_35", 3, 5, 0);
    rd("reclr_ff", 15, 15, 0);
    rd("reclr_10", 1, 0, 0);
    do_reset();
    for (int i = 0; i < 100; i++) tick();
    check("mid_busy", BUSY, 1);
    do_reset();
    check("mid_drop", WR_DROPPED, 0);
    wait_clear(n);
    check("mid_len", n, 256);
    for (int i = 0; i < 257; i++) begin
      logic [7:0] a;
      a = 8'(i);
      wr(a[3:0], a[7:4], a[1:0]);
      if (i == 254) check("cnt_255", WR_COUNT, 255);
      if (i == 255) check("cnt_wrap", WR_COUNT, 0);
    end
    check("cnt_257", WR_COUNT, 1);
    check("final_drop", WR_DROPPED, 0);
    rd("wrap_rd", 6, 0, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
